pmem_scheduler: RTL and testbench

- Sequences the single shared cacheline adaptor between the instruction cache and the data cache, one transaction at a time.
- Sits between the two cache pmem-side ports and the adaptor's line port.
- The data cache has priority. A streak counter bounds instruction-fetch starvation.
- Inserts one recovery cycle after every response so that a stale request is never reissued.

---
 rtl/adaptor_types.sv | 7 +
 rtl/pmem_scheduler_pkg.sv | 13 +
 rtl/pmem_sched_prio.sv | 59 +++++
 rtl/pmem_scheduler.sv | 108 ++++++++++
 tb/tb_pmem_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/adaptor_types.sv
// Shared cacheline adaptor types.
// LINE_W : width of one cacheline in bits.
// line_t : one cacheline as moved between the caches and the adaptor.
package adaptor_types;
  localparam int LINE_W = 256;
  typedef logic [LINE_W-1:0] line_t;
endpackage

// File: rtl/pmem_scheduler_pkg.sv
// Types local to the pmem scheduler.
// sched_state_t : scheduler FSM states.
// STREAK_W      : width of the data-grant streak counter.
package pmem_scheduler_pkg;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RECOVER = 2'd3
  } sched_state_t;
endpackage

// File: rtl/pmem_sched_prio.sv
// IDLE grant decision between icache and dcache, plus the data-grant streak.
// The dcache wins a contested cycle until MAX_D_STREAK consecutive data
// grants have been given while the icache waits; then the icache gets one.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   arb_en   : scheduler is in IDLE; the decision is only taken then
//   ireq     : icache requesting
//   dreq     : dcache requesting (read or write-back)
//   grant_i  : take the icache this cycle
//   grant_d  : take the dcache this cycle
module pmem_sched_prio
  import pmem_scheduler_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic ireq,
  input  logic dreq,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;

  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    streak_nxt = streak;
    if (arb_en) begin
      if (dreq && !ireq) begin
        grant_d    = 1'b1;
        streak_nxt = '0;
      end else if (ireq && !dreq) begin
        grant_i    = 1'b1;
        streak_nxt = '0;
      end else if (ireq && dreq) begin
        // Streak only counts data grants that made the icache wait.
        if (streak < STREAK_MAX) begin
          grant_d    = 1'b1;
          streak_nxt = streak + 1'b1;
        end else begin
          grant_i    = 1'b1;
          streak_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) streak <= '0;
    else     streak <= streak_nxt;
  end

endmodule

// File: rtl/pmem_scheduler.sv
// Shares one cacheline adaptor between icache and dcache, one transaction
// at a time, with a recovery cycle after each response so a cache that is
// still dropping its request is never granted again.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   instr_cache_*        : icache pmem-side port (write is ignored)
//   data_cache_*         : dcache pmem-side port
//   cache_address/read/write/to_pmem : command to the adaptor
//   pmem_to_cache, cache_resp        : adaptor read data and done pulse
//   busy                 : scheduler is not in IDLE
//
// state   | meaning
// IDLE    | no command driven; arbitrate requests every cycle
// GNT_I   | icache read driven to the adaptor until cache_resp
// GNT_D   | dcache read or write-back driven until cache_resp
// RECOVER | one quiet cycle while the served cache drops its request
module pmem_scheduler
  import pmem_scheduler_pkg::*;
#(
  parameter int LINE_W       = adaptor_types::LINE_W,
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] instr_cache_address,
  input  logic              instr_cache_read,
  input  logic              instr_cache_write,
  output logic [LINE_W-1:0] instr_pmem_to_cache,
  output logic              instr_cache_resp,
  input  logic [ADDR_W-1:0] data_cache_address,
  input  logic              data_cache_read,
  input  logic              data_cache_write,
  input  logic [LINE_W-1:0] data_cache_to_pmem,
  output logic [LINE_W-1:0] data_pmem_to_cache,
  output logic              data_cache_resp,
  output logic [ADDR_W-1:0] cache_address,
  output logic              cache_read,
  output logic              cache_write,
  output logic [LINE_W-1:0] cache_to_pmem,
  input  logic [LINE_W-1:0] pmem_to_cache,
  input  logic              cache_resp,
  output logic              busy
);

  sched_state_t state, state_nxt;
  logic grant_i, grant_d;

  // The icache never writes back; its write strobe is deliberately unused.
  logic unused_instr_write;
  assign unused_instr_write = instr_cache_write;

  pmem_sched_prio #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state == IDLE),
    .ireq   (instr_cache_read),
    .dreq   (data_cache_read | data_cache_write),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    cache_address    = '0;
    cache_read       = 1'b0;
    cache_write      = 1'b0;
    cache_to_pmem    = '0;
    instr_cache_resp = 1'b0;
    data_cache_resp  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nxt = GNT_D;
        else if (grant_i) state_nxt = GNT_I;
      end
      GNT_I: begin
        cache_address    = instr_cache_address;
        cache_read       = 1'b1;
        instr_cache_resp = cache_resp;
        if (cache_resp) state_nxt = RECOVER;
      end
      GNT_D: begin
        cache_address   = data_cache_address;
        cache_to_pmem   = data_cache_to_pmem;
        // Write-back wins if a cache ever raises read and write together.
        cache_write     = data_cache_write;
        cache_read      = !data_cache_write;
        data_cache_resp = cache_resp;
        if (cache_resp) state_nxt = RECOVER;
      end
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is broadcast; each cache qualifies it with its own resp.
  assign instr_pmem_to_cache = pmem_to_cache;
  assign data_pmem_to_cache  = pmem_to_cache;
  assign busy                = (state != IDLE);

endmodule

// File: tb/tb_pmem_scheduler.sv
module tb_pmem_scheduler;
  import pmem_scheduler_pkg::*;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] instr_cache_address;
  logic              instr_cache_read;
  logic              instr_cache_write;
  logic [LINE_W-1:0] instr_pmem_to_cache;
  logic              instr_cache_resp;
  logic [ADDR_W-1:0] data_cache_address;
  logic              data_cache_read;
  logic              data_cache_write;
  logic [LINE_W-1:0] data_cache_to_pmem;
  logic [LINE_W-1:0] data_pmem_to_cache;
  logic              data_cache_resp;
  logic [ADDR_W-1:0] cache_address;
  logic              cache_read;
  logic              cache_write;
  logic [LINE_W-1:0] cache_to_pmem;
  logic [LINE_W-1:0] pmem_to_cache;
  logic              cache_resp;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pmem_scheduler #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .MAX_D_STREAK(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_cache_address(instr_cache_address),
    .instr_cache_read   (instr_cache_read),
    .instr_cache_write  (instr_cache_write),
    .instr_pmem_to_cache(instr_pmem_to_cache),
    .instr_cache_resp   (instr_cache_resp),
    .data_cache_address (data_cache_address),
    .data_cache_read    (data_cache_read),
    .data_cache_write   (data_cache_write),
    .data_cache_to_pmem (data_cache_to_pmem),
    .data_pmem_to_cache (data_pmem_to_cache),
    .data_cache_resp    (data_cache_resp),
    .cache_address      (cache_address),
    .cache_read         (cache_read),
    .cache_write        (cache_write),
    .cache_to_pmem      (cache_to_pmem),
    .pmem_to_cache      (pmem_to_cache),
    .cache_resp         (cache_resp),
    .busy               (busy)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  localparam logic [ADDR_W-1:0] I_ADDR = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] D_ADDR = 32'h0000_4000;

  logic [LINE_W-1:0] line_a5;
  logic [LINE_W-1:0] line_rd;
  logic [6:0]        exp_is_d;
  logic [3:0]        exp_streak [7];
  int                d_left;
  logic              i_pend;

  initial begin
    line_a5 = {32{8'hA5}};
    line_rd = {8{32'hDEAD_0001}};
    // Grant order D,D,D,D,I,D,D (bit k = grant k is a data grant).
    exp_is_d = 7'b110_1111;
    exp_streak[0] = 4'd1; exp_streak[1] = 4'd2; exp_streak[2] = 4'd3;
    exp_streak[3] = 4'd4; exp_streak[4] = 4'd0; exp_streak[5] = 4'd0;
    exp_streak[6] = 4'd0;

    rst = 1'b1;
    instr_cache_address = '0; instr_cache_read = 0; instr_cache_write = 0;
    data_cache_address = '0; data_cache_read = 0; data_cache_write = 0;
    data_cache_to_pmem = '0; pmem_to_cache = '0; cache_resp = 0;
    step(); step(); settle();
    chk("rst_state", dut.state, IDLE);
    chk("rst_streak", dut.u_prio.streak, 4'd0);
    chk("rst_read", cache_read, 1'b0);
    chk("rst_write", cache_write, 1'b0);
    chk("rst_addr", cache_address, '0);
    chk("rst_wdata", cache_to_pmem, '0);
    chk("rst_resps", {instr_cache_resp, data_cache_resp}, 2'b00);
    chk("rst_busy", busy, 1'b0);

    // Lone icache read, adaptor responds 4 cycles after the command.
    step(); rst = 0;
    step(); instr_cache_read = 1; instr_cache_address = 32'h0000_1000; settle();
    chk("i_no_cmd_yet", cache_read, 1'b0);
    step(); settle();
    chk("i_cmd_read", cache_read, 1'b1);
    chk("i_cmd_write", cache_write, 1'b0);
    chk("i_cmd_addr", cache_address, 32'h0000_1000);
    step(); step(); step(); settle();
    chk("i_wait_resp", instr_cache_resp, 1'b0);
    step(); cache_resp = 1; pmem_to_cache = line_rd; settle();
    chk("i_resp", {instr_cache_resp, data_cache_resp}, 2'b10);
    chk("i_rdata", instr_pmem_to_cache, line_rd);
    step(); cache_resp = 0; instr_cache_read = 0; settle();
    chk("i_recover", dut.state, RECOVER);
    chk("i_recover_quiet", {cache_read, cache_write, instr_cache_resp}, 3'b000);
    step(); settle();
    chk("i_back_idle", busy, 1'b0);

    // Lone dcache write-back.
    data_cache_write = 1; data_cache_address = 32'h0000_2040;
    data_cache_to_pmem = line_a5;
    step(); settle();
    chk("d_wr_write", cache_write, 1'b1);
    chk("d_wr_read", cache_read, 1'b0);
    chk("d_wr_addr", cache_address, 32'h0000_2040);
    chk("d_wr_data", cache_to_pmem, line_a5);
    step(); cache_resp = 1; settle();
    chk("d_wr_resp", {instr_cache_resp, data_cache_resp}, 2'b01);
    step(); cache_resp = 0; data_cache_write = 0; settle();
    chk("d_wr_busy_r1", busy, 1'b1);
    step(); settle();
    chk("d_wr_busy_r2", busy, 1'b0);

    // Starvation bound: icache held, dcache issues 6 back-to-back reads.
    i_pend = 1; d_left = 6;
    instr_cache_address = I_ADDR; data_cache_address = D_ADDR;
    data_cache_to_pmem = '0;
    for (int k = 0; k < 7; k++) begin
      instr_cache_read = i_pend;
      data_cache_read  = (d_left > 0);
      step(); settle();
      chk($sformatf("streak_addr%0d", k), cache_address,
          exp_is_d[k] ? D_ADDR : I_ADDR);
      chk($sformatf("streak_cnt%0d", k), dut.u_prio.streak, exp_streak[k]);
      step(); cache_resp = 1; settle();
      chk($sformatf("streak_resp%0d", k), {instr_cache_resp, data_cache_resp},
          exp_is_d[k] ? 2'b01 : 2'b10);
      step(); cache_resp = 0;
      if (exp_is_d[k]) begin d_left--; data_cache_read = 0; end
      else begin i_pend = 0; instr_cache_read = 0; end
      step();
    end

    // Simultaneous first requests: data first, then instruction.
    instr_cache_read = 1; data_cache_read = 1;
    step(); settle();
    chk("sim_first_d", cache_address, D_ADDR);
    step(); cache_resp = 1; settle();
    chk("sim_d_resp", data_cache_resp, 1'b1);
    step(); cache_resp = 0; data_cache_read = 0; settle();
    chk("sim_recover", dut.state, RECOVER);
    step(); settle();
    chk("sim_idle", dut.state, IDLE);
    step(); settle();
    chk("sim_then_i", cache_address, I_ADDR);
    chk("sim_i_state", dut.state, GNT_I);
    step(); cache_resp = 1; settle();
    chk("sim_i_resp", instr_cache_resp, 1'b1);
    step(); cache_resp = 0; instr_cache_read = 0;
    step();

    // Reset in the middle of a data grant, then a stray adaptor response.
    data_cache_read = 1;
    step(); settle();
    chk("rst_mid_gnt", dut.state, GNT_D);
    rst = 1;
    step(); settle();
    chk("rst_mid_state", dut.state, IDLE);
    chk("rst_mid_outs", {cache_read, cache_write, busy, data_cache_resp}, 4'b0000);
    chk("rst_mid_addr", cache_address, '0);
    rst = 0; data_cache_read = 0; cache_resp = 1; settle();
    chk("stray_resp", {instr_cache_resp, data_cache_resp}, 2'b00);
    step(); cache_resp = 0; settle();
    chk("stray_idle", busy, 1'b0);

    // Illegal read+write from dcache with icache write noise.
    instr_cache_write = 1; data_cache_read = 1; data_cache_write = 1;
    data_cache_to_pmem = line_a5;
    step(); settle();
    chk("rw_write_only", {cache_write, cache_read}, 2'b10);
    chk("rw_state", dut.state, GNT_D);
    step(); cache_resp = 1; settle();
    chk("rw_resp", data_cache_resp, 1'b1);
    step(); cache_resp = 0; data_cache_read = 0; data_cache_write = 0;
    step(); step(); settle();
    chk("iwrite_no_grant", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
